// File: rtl/data_cache_if.sv
`default_nettype none
// ============================================================================
// Module      : data_cache_if
// Description : CPU load/store port and block-memory port of the data cache.
// Revision    : 1.0 - initial release
// ============================================================================
interface data_cache_if;
    logic        READ;
    logic        WRITE;
    logic [7:0]  ADDRESS;
    logic [7:0]  WRITEDATA;
    logic [7:0]  READDATA;
    logic        BUSYWAIT;
    logic        mem_read;
    logic        mem_write;
    logic [5:0]  mem_address;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;
    logic        mem_busywait;

    // Cache view: responder towards the CPU, initiator towards memory.
    modport slave (
        input  READ, WRITE, ADDRESS, WRITEDATA, mem_readdata, mem_busywait,
        output READDATA, BUSYWAIT, mem_read, mem_write, mem_address, mem_writedata
    );

    // Environment view: the CPU and the block memory together.
    modport master (
        output READ, WRITE, ADDRESS, WRITEDATA, mem_readdata, mem_busywait,
        input  READDATA, BUSYWAIT, mem_read, mem_write, mem_address, mem_writedata
    );
endinterface
`default_nettype wire

// File: rtl/data_cache.sv
`default_nettype none
// ============================================================================
// Module      : data_cache
// Description : Direct-mapped write-back/write-allocate cache, 8 lines x 4 B.
// Revision    : 1.0 - initial release
// ============================================================================
module data_cache (
    input  logic         CLK,
    input  logic         RESET,
    data_cache_if.slave  bus
);
    localparam logic [1:0] c_IDLE      = 2'd0;
    localparam logic [1:0] c_MEM_WRITE = 2'd1;
    localparam logic [1:0] c_MEM_READ  = 2'd2;
    localparam logic [1:0] c_UPDATE    = 2'd3;

    logic [1:0]  r_state;
    logic        r_seen_busy;
    logic [7:0]  r_valid;
    logic [7:0]  r_dirty;
    logic [2:0]  r_tag  [8];
    logic [31:0] r_data [8];
    logic [31:0] r_fill;

    logic [2:0]  w_tag;
    logic [2:0]  w_index;
    logic [1:0]  w_offset;
    logic        w_req;
    logic        w_store;
    logic        w_hit;
    logic        w_mem_done;

    assign w_tag      = bus.ADDRESS[7:5];
    assign w_index    = bus.ADDRESS[4:2];
    assign w_offset   = bus.ADDRESS[1:0];
    assign w_req      = bus.READ | bus.WRITE;
    // READ and WRITE together is treated as a store.
    assign w_store    = bus.WRITE;
    assign w_hit      = r_valid[w_index] && (r_tag[w_index] == w_tag);
    // Done only once busy has been observed high in the current memory state.
    assign w_mem_done = r_seen_busy && !bus.mem_busywait;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state     <= c_IDLE;
            r_seen_busy <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    r_seen_busy <= 1'b0;
                    if (w_req && !w_hit) begin
                        r_state <= (r_valid[w_index] && r_dirty[w_index]) ? c_MEM_WRITE : c_MEM_READ;
                    end
                end
                c_MEM_WRITE, c_MEM_READ: begin
                    if (bus.mem_busywait) begin
                        r_seen_busy <= 1'b1;
                    end else if (r_seen_busy) begin
                        r_seen_busy <= 1'b0;
                        r_state     <= (r_state == c_MEM_WRITE) ? c_MEM_READ : c_UPDATE;
                    end
                end
                c_UPDATE: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if ((r_state == c_MEM_READ) && w_mem_done) begin
            r_fill <= bus.mem_readdata;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_valid <= 8'd0;
            r_dirty <= 8'd0;
        end else if (r_state == c_UPDATE) begin
            r_valid[w_index] <= 1'b1;
            r_dirty[w_index] <= 1'b0;
        end else if ((r_state == c_IDLE) && w_store && w_hit) begin
            r_dirty[w_index] <= 1'b1;
        end
    end

    // Tag and data arrays carry no reset; validity alone qualifies them.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            if (r_state == c_UPDATE) begin
                r_tag[w_index]  <= w_tag;
                r_data[w_index] <= r_fill;
            end else if ((r_state == c_IDLE) && w_store && w_hit) begin
                r_data[w_index][{w_offset, 3'b000} +: 8] <= bus.WRITEDATA;
            end
        end
    end

    assign bus.READDATA = r_data[w_index][{w_offset, 3'b000} +: 8];
    assign bus.BUSYWAIT = (r_state != c_IDLE) || (w_req && !w_hit);
    assign bus.mem_read  = (r_state == c_MEM_READ);
    assign bus.mem_write = (r_state == c_MEM_WRITE);

    always_comb begin
        bus.mem_address   = 6'd0;
        bus.mem_writedata = 32'd0;
        case (r_state)
            c_MEM_WRITE: begin
                bus.mem_address   = {r_tag[w_index], w_index};
                bus.mem_writedata = r_data[w_index];
            end
            c_MEM_READ: begin
                bus.mem_address   = {w_tag, w_index};
            end
            default: begin
                bus.mem_address   = 6'd0;
                bus.mem_writedata = 32'd0;
            end
        endcase
    end
endmodule
`default_nettype wire

// File: tb/tb_data_cache.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_cache
// Description : Scoreboard bench for data_cache with a behavioral block memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_cache;
    logic CLK = 1'b0;
    logic RESET;

    data_cache_if bus ();

    data_cache dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit         is_read;
        logic [7:0] data;
    } cpu_exp_t;

    typedef struct {
        bit          is_write;
        logic [5:0]  addr;
        logic [31:0] wdata;
        int          cycles;
    } mem_exp_t;

    cpu_exp_t    cpu_q[$];
    mem_exp_t    mem_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] mem [64];
    int          mem_pre  = 0;
    int          mem_busy = 1;

    logic [7:0] b2b_addr [8] = '{8'h00, 8'h05, 8'h0A, 8'h0F, 8'h10, 8'h15, 8'h1A, 8'h1F};
    logic [7:0] b2b_data [8] = '{8'h11, 8'hAB, 8'h0A, 8'h0F, 8'h10, 8'h15, 8'h1A, 8'h1F};
    logic [7:0] fill_data[8] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C};

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic exp_mem(bit wr, logic [5:0] addr, logic [31:0] wdata, int cycles);
        mem_q.push_back('{is_write: wr, addr: addr, wdata: wdata, cycles: cycles});
    endtask

    // Issue one CPU request, hold it until BUSYWAIT is low, verify the stall length.
    task automatic cpu_req(bit rd, bit wr, logic [7:0] addr, logic [7:0] wdata,
                           logic [7:0] exp_data, int exp_stall);
        int stall = 0;
        @(posedge CLK); #1;
        bus.READ      = rd;
        bus.WRITE     = wr;
        bus.ADDRESS   = addr;
        bus.WRITEDATA = wdata;
        cpu_q.push_back('{is_read: (rd && !wr), data: exp_data});
        forever begin
            @(negedge CLK);
            if (!bus.BUSYWAIT) break;
            stall++;
            if (stall > 60) begin
                check("busywait_timeout", 32'(stall), 32'(exp_stall));
                break;
            end
        end
        check("stall_cycles", 32'(stall), 32'(exp_stall));
    endtask

    task automatic cpu_idle();
        @(posedge CLK); #1;
        bus.READ  = 1'b0;
        bus.WRITE = 1'b0;
    endtask

    // Monitor: every completed CPU request is matched against the scoreboard.
    initial begin
        cpu_exp_t e;
        forever begin
            @(negedge CLK);
            if (!RESET && (bus.READ || bus.WRITE) && !bus.BUSYWAIT) begin
                if (cpu_q.size() == 0) begin
                    check("cpu_unexpected_completion", 32'd1, 32'd0);
                end else begin
                    e = cpu_q.pop_front();
                    if (e.is_read) check("readdata", 32'(bus.READDATA), 32'(e.data));
                end
            end
        end
    end

    // Block memory: optional delay before busy rises, then busy for mem_busy cycles.
    initial begin
        bit          wr;
        logic [5:0]  a;
        logic [31:0] wd;
        int          cyc;
        bit          aborted;
        mem_exp_t    e;
        bus.mem_busywait = 1'b0;
        bus.mem_readdata = 32'd0;
        forever begin
            @(negedge CLK);
            if (bus.mem_read || bus.mem_write) begin
                wr      = bus.mem_write;
                a       = bus.mem_address;
                wd      = bus.mem_writedata;
                cyc     = 1;
                aborted = 1'b0;
                for (int i = 0; i < mem_pre + mem_busy; i++) begin
                    bus.mem_busywait = (i >= mem_pre);
                    @(negedge CLK);
                    if (!(bus.mem_read || bus.mem_write)) begin
                        aborted = 1'b1;
                        break;
                    end
                    if ((bus.mem_write == wr) && (bus.mem_address == a)) cyc++;
                end
                bus.mem_busywait = 1'b0;
                if (!aborted) begin
                    if (wr) mem[a] = wd;
                    else    bus.mem_readdata = mem[a];
                    if (mem_q.size() == 0) begin
                        check("mem_unexpected_transaction", 32'd1, 32'd0);
                    end else begin
                        e = mem_q.pop_front();
                        check("mem_kind_write", 32'(wr), 32'(e.is_write));
                        check("mem_address", 32'(a), 32'(e.addr));
                        if (wr) check("mem_writedata", wd, e.wdata);
                        check("mem_request_cycles", 32'(cyc), 32'(e.cycles));
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_checks);
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem[i] = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
        end
        mem[0] = 32'h44332211;

        RESET = 1'b1;
        bus.READ = 1'b0; bus.WRITE = 1'b0; bus.ADDRESS = 8'h00; bus.WRITEDATA = 8'h00;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("reset_busywait", 32'(bus.BUSYWAIT), 32'd0);
        check("reset_mem_read", 32'(bus.mem_read), 32'd0);
        check("reset_mem_write", 32'(bus.mem_write), 32'd0);
        check("reset_mem_address", 32'(bus.mem_address), 32'd0);
        check("reset_mem_writedata", bus.mem_writedata, 32'd0);
        @(posedge CLK); #1;
        RESET = 1'b0;

        // Clean miss, then hit in the same line.
        exp_mem(1'b0, 6'h00, 32'd0, 2);
        cpu_req(1'b1, 1'b0, 8'h00, 8'h00, 8'h11, 4);
        cpu_req(1'b1, 1'b0, 8'h03, 8'h00, 8'h44, 0);

        // Load line 1, store to it, read the stored byte back.
        exp_mem(1'b0, 6'h01, 32'd0, 2);
        cpu_req(1'b1, 1'b0, 8'h05, 8'h00, 8'h05, 4);
        cpu_req(1'b0, 1'b1, 8'h05, 8'hAB, 8'h00, 0);
        cpu_req(1'b1, 1'b0, 8'h05, 8'h00, 8'hAB, 0);

        // Dirty conflict on line 1: write-back then fetch.
        exp_mem(1'b1, 6'h01, 32'h0706AB04, 2);
        exp_mem(1'b0, 6'h09, 32'd0, 2);
        cpu_req(1'b1, 1'b0, 8'h25, 8'h00, 8'h25, 6);

        // Slow memory: five busy cycles.
        mem_busy = 5;
        exp_mem(1'b0, 6'h02, 32'd0, 6);
        cpu_req(1'b1, 1'b0, 8'h08, 8'h00, 8'h08, 8);

        // Memory that is slow to raise busy.
        mem_pre = 3; mem_busy = 2;
        exp_mem(1'b0, 6'h03, 32'd0, 6);
        cpu_req(1'b1, 1'b0, 8'h0E, 8'h00, 8'h0E, 8);
        mem_pre = 0;
        cpu_idle();

        // Reset while a fetch is outstanding.
        mem_busy = 5;
        @(posedge CLK); #1;
        bus.READ = 1'b1; bus.WRITE = 1'b0; bus.ADDRESS = 8'h10;
        repeat (3) @(negedge CLK);
        check("pre_reset_mem_read", 32'(bus.mem_read), 32'd1);
        @(posedge CLK); #1;
        RESET = 1'b1; bus.READ = 1'b0;
        repeat (2) @(negedge CLK);
        check("midmiss_reset_mem_read", 32'(bus.mem_read), 32'd0);
        check("midmiss_reset_mem_write", 32'(bus.mem_write), 32'd0);
        check("midmiss_reset_busywait", 32'(bus.BUSYWAIT), 32'd0);
        @(posedge CLK); #1;
        RESET = 1'b0;
        mem_busy = 1;

        // Line 0 was invalidated by reset, so this misses again.
        exp_mem(1'b0, 6'h00, 32'd0, 2);
        cpu_req(1'b1, 1'b0, 8'h00, 8'h00, 8'h11, 4);

        for (int i = 1; i < 8; i++) begin
            exp_mem(1'b0, 6'(i), 32'd0, 2);
            cpu_req(1'b1, 1'b0, 8'(4*i), 8'h00, fill_data[i], 4);
        end

        // Back-to-back hits across all eight lines.
        for (int i = 0; i < 8; i++) begin
            cpu_req(1'b1, 1'b0, b2b_addr[i], 8'h00, b2b_data[i], 0);
        end

        // READ and WRITE together behave as a store.
        cpu_req(1'b1, 1'b1, 8'h1F, 8'h5C, 8'h00, 0);
        cpu_req(1'b1, 1'b0, 8'h1F, 8'h00, 8'h5C, 0);
        cpu_idle();

        repeat (3) @(negedge CLK);
        check("cpu_queue_drained", 32'(cpu_q.size()), 32'd0);
        check("mem_queue_drained", 32'(mem_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
